// File: rtl/pipe_hazard_unit.sv
// Hazard detection and operand-forwarding control for the five-stage pipeline.
// Tracks in-flight register writers and stalls only when load data is not yet forwardable.
module pipe_hazard_unit #(
  parameter int RA_W       = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic [RA_W-1:0]  id_wn,
  input  logic             flush,
  output logic             stall,
  output logic [SEL_W-1:0] fwd_a,
  output logic [SEL_W-1:0] fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic            v;
    logic            wreg;
    logic            m2reg;
    logic [RA_W-1:0] wn;
  } sb_entry_t;

  sb_entry_t        sb_q [1:DEPTH];
  sb_entry_t        sb_d [1:DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             haz_a, haz_b;

  // Scanning oldest to youngest lets the youngest matching producer win.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    fwd_a = '0;
    haz_a = 1'b0;
    if (id_use_rs && id_rs != '0) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (sb_q[k].v && sb_q[k].wreg && sb_q[k].wn == id_rs) begin
          fwd_a = SEL_W'(k);
          haz_a = sb_q[k].m2reg && (k < LOAD_STAGE);
        end
      end
    end
  end

  always_comb begin
    fwd_b = '0;
    haz_b = 1'b0;
    if (id_use_rt && id_rt != '0) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (sb_q[k].v && sb_q[k].wreg && sb_q[k].wn == id_rt) begin
          fwd_b = SEL_W'(k);
          haz_b = sb_q[k].m2reg && (k < LOAD_STAGE);
        end
      end
    end
  end

  // A taken branch kills the ID instruction, so it can never be the cause of a stall.
  assign stall = id_valid & ~flush & (haz_a | haz_b);

  always_comb begin
    sb_d[1].v     = id_valid & ~flush & ~stall;
    sb_d[1].wreg  = id_wreg;
    sb_d[1].m2reg = id_m2reg;
    sb_d[1].wn    = id_wn;
    for (int k = 2; k <= DEPTH; k++) begin
      sb_d[k] = sb_q[k-1];
    end
    cnt_d = cnt_q;
    if (stall && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments, and every scoreboard entry is reset
  // because stale valid bits would otherwise create phantom hazards after clr.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int k = 1; k <= DEPTH; k++) begin
        sb_q[k] <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int k = 1; k <= DEPTH; k++) begin
        sb_q[k] <= sb_d[k];
      end
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: default, 4-bit counter and DEPTH=4/LOAD_STAGE=3 instances
// share the ID-stage stimulus; each is checked where its behaviour is known.
module tb_pipe_hazard_unit;

  logic       clk = 1'b0;
  logic       clr;
  logic       id_valid, id_use_rs, id_use_rt, id_wreg, id_m2reg, flush;
  logic [4:0] id_rs, id_rt, id_wn;

  logic        stall_d;
  logic [1:0]  fwd_a_d, fwd_b_d;
  logic [15:0] cnt_d;
  logic        stall_s;
  logic [1:0]  fwd_a_s, fwd_b_s;
  logic [3:0]  cnt_s;
  logic        stall_4;
  logic [2:0]  fwd_a_4, fwd_b_4;
  logic [15:0] cnt_4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_hazard_unit u_dut (
    .clk(clk), .clr(clr), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
    .id_wn(id_wn), .flush(flush), .stall(stall_d), .fwd_a(fwd_a_d), .fwd_b(fwd_b_d),
    .stall_cnt(cnt_d)
  );

  pipe_hazard_unit #(.CNT_W(4)) u_sat (
    .clk(clk), .clr(clr), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
    .id_wn(id_wn), .flush(flush), .stall(stall_s), .fwd_a(fwd_a_s), .fwd_b(fwd_b_s),
    .stall_cnt(cnt_s)
  );

  pipe_hazard_unit #(.DEPTH(4), .LOAD_STAGE(3), .SEL_W(3)) u_d4 (
    .clk(clk), .clr(clr), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
    .id_wn(id_wn), .flush(flush), .stall(stall_4), .fwd_a(fwd_a_4), .fwd_b(fwd_b_4),
    .stall_cnt(cnt_4)
  );

  typedef struct {
    string name;
    int v, f, rs, rt, ur, ut, w, m, wn;
    int e_stall, e_a, e_b, e_cnt;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_id(input int v, input int f, input int rs, input int rt, input int ur,
                        input int ut, input int w, input int m, input int wn);
    id_valid  = v[0];
    flush     = f[0];
    id_rs     = 5'(rs);
    id_rt     = 5'(rt);
    id_use_rs = ur[0];
    id_use_rt = ut[0];
    id_wreg   = w[0];
    id_m2reg  = m[0];
    id_wn     = 5'(wn);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    #1;
    clr = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            name           v f rs rt ur ut w m wn  st a b cnt
    vecs[0]  = '{"add_r3",       1,0, 1, 2, 1, 1,1,0, 3, 0,0,0,0};
    vecs[1]  = '{"sub_r4_r3r3",  1,0, 3, 3, 1, 1,1,0, 4, 0,1,1,0};
    vecs[2]  = '{"or_r9_r3r0",   1,0, 3, 0, 1, 1,1,0, 9, 0,2,0,0};
    vecs[3]  = '{"lw_r5",        1,0, 1, 0, 1, 0,1,1, 5, 0,0,0,0};
    vecs[4]  = '{"use_r5_stall", 1,0, 5, 7, 1, 1,1,0, 6, 1,0,0,0};
    vecs[5]  = '{"use_r5_fwd",   1,0, 5, 7, 1, 1,1,0, 6, 0,2,0,1};
    vecs[6]  = '{"wr_r8_a",      1,0, 0, 0, 0, 0,1,0, 8, 0,0,0,1};
    vecs[7]  = '{"rd_r6",        1,0, 6, 0, 1, 0,0,0, 0, 0,2,0,1};
    vecs[8]  = '{"wr_r8_b",      1,0, 8, 6, 1, 1,1,0, 8, 0,2,3,1};
    vecs[9]  = '{"rd_r8_young",  1,0, 8, 8, 1, 1,0,0, 0, 0,1,1,1};
    vecs[10] = '{"wr_r0",        1,0, 0, 0, 0, 0,1,0, 0, 0,0,0,1};
    vecs[11] = '{"rd_r0",        1,0, 0, 0, 1, 1,0,0, 0, 0,0,0,1};
    vecs[12] = '{"lw_r0",        1,0, 0, 0, 0, 0,1,1, 0, 0,0,0,1};
    vecs[13] = '{"rd_r0_lw",     1,0, 0, 0, 1, 1,0,0, 0, 0,0,0,1};
    vecs[14] = '{"lw_r10",       1,0, 0, 0, 0, 0,1,1,10, 0,0,0,1};
    vecs[15] = '{"inval_rd_r10", 0,0,10, 0, 1, 0,0,0, 0, 0,1,0,1};
    vecs[16] = '{"rd_r10_late",  1,0,10,10, 1, 0,0,0, 0, 0,2,0,1};

    clr = 1'b1;
    set_id(1, 0, 5, 5, 1, 1, 1, 1, 5);
    check("reset stall", stall_d, 0);
    check("reset fwd_a", fwd_a_d, 0);
    check("reset cnt", cnt_d, 0);
    tick();
    clr = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Table: one row per cycle, outputs checked before the edge that retires the row.
    for (int i = 0; i < 17; i++) begin
      set_id(vecs[i].v, vecs[i].f, vecs[i].rs, vecs[i].rt, vecs[i].ur, vecs[i].ut,
             vecs[i].w, vecs[i].m, vecs[i].wn);
      check({vecs[i].name, " stall"}, stall_d, vecs[i].e_stall);
      check({vecs[i].name, " cnt"}, cnt_d, vecs[i].e_cnt);
      check({vecs[i].name, " sat stall"}, stall_s, vecs[i].e_stall);
      check({vecs[i].name, " sat cnt"}, cnt_s, vecs[i].e_cnt);
      if (vecs[i].e_stall == 0) begin
        check({vecs[i].name, " fwd_a"}, fwd_a_d, vecs[i].e_a);
        check({vecs[i].name, " fwd_b"}, fwd_b_d, vecs[i].e_b);
        check({vecs[i].name, " sat fwd_a"}, fwd_a_s, vecs[i].e_a);
        check({vecs[i].name, " sat fwd_b"}, fwd_b_s, vecs[i].e_b);
      end
      tick();
    end

    // Bubble behind a load-use stall: entry 1 must not hold the stalled instruction.
    do_reset();
    set_id(1, 0, 1, 0, 1, 0, 1, 1, 5);
    tick();
    set_id(1, 0, 5, 7, 1, 1, 1, 0, 6);
    check("lu stall", stall_d, 1);
    tick();
    set_id(1, 0, 6, 0, 1, 0, 0, 0, 0);
    check("lu bubble fwd_a", fwd_a_d, 0);
    set_id(1, 0, 5, 7, 1, 1, 1, 0, 6);
    check("lu retry stall", stall_d, 0);
    check("lu retry fwd_a", fwd_a_d, 2);
    check("lu retry fwd_b", fwd_b_d, 0);
    check("lu cnt", cnt_d, 1);

    // Asynchronous clear in the middle of a stall.
    set_id(1, 0, 1, 0, 1, 0, 1, 1, 5);
    tick();
    set_id(1, 0, 5, 5, 1, 1, 1, 0, 6);
    check("pre-clr stall", stall_d, 1);
    clr = 1'b1;
    #1;
    check("clr stall", stall_d, 0);
    check("clr fwd_a", fwd_a_d, 0);
    check("clr fwd_b", fwd_b_d, 0);
    check("clr cnt", cnt_d, 0);
    tick();
    check("clr held cnt", cnt_d, 0);
    check("clr held stall", stall_d, 0);
    clr = 1'b0;
    #1;
    tick();
    set_id(1, 0, 6, 0, 1, 0, 0, 0, 0);
    check("post-clr load fwd_a", fwd_a_d, 1);
    check("post-clr stall", stall_d, 0);

    // Flush in the hazard cycle wins over stall and leaves a bubble.
    do_reset();
    set_id(1, 0, 1, 0, 1, 0, 1, 1, 5);
    tick();
    set_id(1, 1, 5, 7, 1, 1, 1, 0, 6);
    check("flush stall", stall_d, 0);
    check("flush cnt", cnt_d, 0);
    tick();
    check("flush cnt after", cnt_d, 0);
    set_id(1, 0, 6, 0, 1, 0, 0, 0, 0);
    check("flush bubble fwd_a", fwd_a_d, 0);
    set_id(1, 0, 5, 0, 1, 0, 0, 0, 0);
    check("flush lw fwd_a", fwd_a_d, 2);
    check("flush lw stall", stall_d, 0);

    // Counter saturation: 20 load-use stalls.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_id(1, 0, 1, 0, 1, 0, 1, 1, 5);
      tick();
      set_id(1, 0, 5, 7, 1, 1, 1, 0, 6);
      check($sformatf("sat stall %0d", i), stall_s, 1);
      tick();
    end
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("sat cnt 4b", cnt_s, 15);
    check("sat cnt 16b", cnt_d, 20);

    // DEPTH=4, LOAD_STAGE=3: two stall cycles, then forward from stage 3.
    do_reset();
    set_id(1, 0, 1, 0, 1, 0, 1, 1, 5);
    tick();
    set_id(1, 0, 5, 7, 1, 1, 1, 0, 6);
    check("d4 stall 1", stall_4, 1);
    tick();
    check("d4 stall 2", stall_4, 1);
    tick();
    check("d4 stall 3", stall_4, 0);
    check("d4 fwd_a", fwd_a_4, 3);
    check("d4 fwd_b", fwd_b_4, 0);
    check("d4 cnt", cnt_4, 2);
    check("d3 cnt", cnt_d, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
